data_dist1_4: RTL and testbench
===============================

Name: data_dist1_4

Overview:
- Distributor back-end for the 4:1 data selector.
- Accepts a stream of WIDTH-bit words through a valid/ready handshake and steers each word into one of four shadow registers.
- Steering is either addressed (in_sel) or auto-sequenced (internal pointer).
- When a frame completes or is flushed, the shadow registers are committed atomically to four registered outputs q1..q4. This gives a double-buffered 1:4 demux that feeds downstream selectors and display scanners.

Parameters:
- WIDTH, 4, data word width of d, shadow registers and q1..q4.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst_n  input  1  asynchronous active-low reset
- d  input  WIDTH  incoming data word
- in_sel  input  2  target channel in addressed mode (0->q1 .. 3->q4)
- auto_mode  input  1  1 = internal pointer selects channel, 0 = in_sel selects channel
- in_valid  input  1  d/in_sel valid this cycle
- in_ready  output  1  block can accept a word this cycle
- flush  input  1  request commit of a partially filled frame
- q1  output  WIDTH  committed channel 0
- q2  output  WIDTH  committed channel 1
- q3  output  WIDTH  committed channel 2
- q4  output  WIDTH  committed channel 3
- q_mask  output  4  channels refreshed by the most recent commit (bit0 = q1)
- frame_done  output  1  one-cycle pulse in the cycle q1..q4 update
- ptr  output  2  current auto-mode pointer

Behaviour:
- Reset (async, rst_n=0):
  - q1..q4 = 0; shadow registers = 0; q_mask = 0; frame_done = 0; ptr = 0.
  - Internal written-mask wmask = 0; state = COLLECT; in_ready = 0 while rst_n = 0.
  - Reset asserted mid-frame discards all shadow contents; no commit occurs.
- Transfer: a word is accepted on a rising edge where in_valid=1 and in_ready=1.
- Channel steering: ch = ptr if auto_mode=1, else in_sel.
  - Accepted word is written to shadow[ch] and sets wmask[ch].
  - Rewriting an already-written channel overwrites shadow[ch]; wmask is unchanged.
- ptr: increments mod 4 on each accepted word in auto mode only.
  - Unchanged in addressed mode.
  - Reset to 0 at every commit.
  - Toggling auto_mode mid-frame takes effect on the next beat; ptr and wmask are not cleared.
- State COLLECT:
  - in_ready = 1.
  - Go to COMMIT on the edge where the next wmask (including this cycle's write) equals 4'b1111.
  - Also go to COMMIT when flush=1 and next wmask != 0.
  - flush=1 with next wmask = 0 is ignored: no commit, no pulse.
  - flush and an accepted word in the same cycle: the word is included in the flushed frame.
- State COMMIT (exactly one cycle):
  - in_ready = 0; incoming words are not accepted.
  - On exit edge: for each channel i with wmask[i]=1, q(i+1) <= shadow[i]; channels with wmask[i]=0 hold their previous q value.
  - Same edge: q_mask <= wmask; frame_done = 1 for the following cycle only; wmask <= 0; ptr <= 0; state <= COLLECT.
  - flush during COMMIT is ignored.
- Shadow registers retain their contents after commit. Only wmask gates the next commit.
- Latency:
  - Last word accepted at edge N -> COMMIT during cycle N..N+1 -> q outputs and frame_done visible after edge N+1.
  - Maximum sustained throughput: 4 words per 5 cycles.
- q1..q4, q_mask and frame_done are registered outputs with no combinational path from any input.
- in_ready depends on state only, never on in_valid.

Test Plan:
- Reset then auto_mode=1, four back-to-back beats d=1,2,3,4 -> after 5th edge q1..q4 = 1,2,3,4, q_mask = 1111, frame_done high exactly 1 cycle, in_ready low exactly the COMMIT cycle, ptr = 0.
- Addressed mode, writes sel=2 d=A, sel=0 d=5, sel=2 d=C, sel=3 d=7, sel=1 d=9 -> single commit after 5th beat; q1=5, q2=9, q3=C, q4=7; no earlier frame_done.
- After the first test, auto_mode=1, two beats d=E,F, then flush -> q1=E, q2=F, q3=3, q4=4 retained, q_mask = 0011, ptr = 0.
- flush asserted with nothing written, and flush asserted in the same cycle as a beat d=6 in addressed mode sel=3 -> first: no pulse, outputs unchanged; second: q4=6, q_mask = 1000.
- in_valid held high continuously for 12 cycles in auto mode, d incrementing from 0 -> exactly 3 commits with q = {0,1,2,3}, {4,5,6,7}, {8,9,A,B}, words offered during COMMIT cycles not lost (held by source), frame_done every 5th cycle.
- Assert rst_n=0 asynchronously (between edges) after 3 beats of a frame -> outputs clear immediately; after release, one new beat d=8 produces no commit; ptr = 1.

Source files
------------

// File: rtl/data_dist1_4.sv
// data_dist1_4 : double-buffered 1:4 demultiplexer / distributor.
//
// Words arrive over a valid/ready handshake and land in one of four shadow
// registers. The channel comes from in_sel in addressed mode, or from an
// internal pointer in auto mode. When every channel has been written, or when
// a flush arrives with at least one channel written, the block spends one
// COMMIT cycle. At the end of that cycle it copies the written shadow
// registers into q1..q4 in one step.
//
// Ports:
//   clk        : system clock, rising edge
//   rst_n      : asynchronous active-low reset
//   d          : incoming data word (WIDTH bits)
//   in_sel     : target channel in addressed mode (0 -> q1 .. 3 -> q4)
//   auto_mode  : 1 = internal pointer steers, 0 = in_sel steers
//   in_valid   : d / in_sel valid this cycle
//   in_ready   : block accepts a word this cycle (state only)
//   flush      : commit a partially filled frame
//   q1..q4     : committed channel outputs (registered)
//   q_mask     : channels refreshed by the latest commit (bit0 = q1)
//   frame_done : one-cycle pulse in the cycle q1..q4 update
//   ptr        : current auto-mode pointer
module data_dist1_4 #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    input  logic [1:0]       in_sel,
    input  logic             auto_mode,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             flush,
    output logic [WIDTH-1:0] q1,
    output logic [WIDTH-1:0] q2,
    output logic [WIDTH-1:0] q3,
    output logic [WIDTH-1:0] q4,
    output logic [3:0]       q_mask,
    output logic             frame_done,
    output logic [1:0]       ptr
);

    typedef enum logic {
        S_COLLECT = 1'b0,
        S_COMMIT  = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_shadow [4];
    logic [WIDTH-1:0] r_q      [4];
    logic [3:0]       r_wmask;
    logic [3:0]       r_q_mask;
    logic             r_frame_done;
    logic [1:0]       r_ptr;

    logic [1:0]       w_ch;
    logic             w_accept;
    logic [3:0]       w_wmask_nxt;

    assign w_ch        = auto_mode ? r_ptr : in_sel;
    assign w_accept    = in_valid && in_ready;
    // Written mask including this cycle's beat; decides whether the frame closes now.
    assign w_wmask_nxt = r_wmask | (w_accept ? (4'b0001 << w_ch) : 4'b0000);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_COLLECT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_COLLECT: begin
                // A flush with nothing written is ignored.
                if ((w_wmask_nxt == 4'b1111) || (flush && (w_wmask_nxt != 4'b0000))) begin
                    w_state_nxt = S_COMMIT;
                end
            end
            S_COMMIT: w_state_nxt = S_COLLECT;
            default:  w_state_nxt = S_COLLECT;
        endcase
    end

    // Output logic: ready in COLLECT only, and held low while reset is applied.
    always_comb begin
        in_ready = (r_state == S_COLLECT) && rst_n;
    end

    // Shadow capture, commit and pointer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                r_shadow[i] <= '0;
                r_q[i]      <= '0;
            end
            r_wmask      <= 4'b0000;
            r_q_mask     <= 4'b0000;
            r_frame_done <= 1'b0;
            r_ptr        <= 2'd0;
        end else begin
            r_frame_done <= 1'b0;
            case (r_state)
                S_COLLECT: begin
                    if (w_accept) begin
                        r_shadow[w_ch] <= d;
                        r_wmask        <= w_wmask_nxt;
                        if (auto_mode) begin
                            r_ptr <= r_ptr + 2'd1;
                        end
                    end
                end
                S_COMMIT: begin
                    // Unwritten channels keep their previous committed value.
                    for (int i = 0; i < 4; i++) begin
                        if (r_wmask[i]) begin
                            r_q[i] <= r_shadow[i];
                        end
                    end
                    r_q_mask     <= r_wmask;
                    r_frame_done <= 1'b1;
                    r_wmask      <= 4'b0000;
                    r_ptr        <= 2'd0;
                end
                default: ;
            endcase
        end
    end

    assign q1         = r_q[0];
    assign q2         = r_q[1];
    assign q3         = r_q[2];
    assign q4         = r_q[3];
    assign q_mask     = r_q_mask;
    assign frame_done = r_frame_done;
    assign ptr        = r_ptr;

endmodule

// File: tb/tb_data_dist1_4.sv
// Testbench for data_dist1_4: a behavioural model pushes the expected frame
// into a scoreboard queue when a commit is due, and each frame_done pulse pops
// one entry and compares it with the outputs.
module tb_data_dist1_4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] d;
    logic [1:0] in_sel;
    logic       auto_mode;
    logic       in_valid;
    logic       in_ready;
    logic       flush;
    logic [3:0] q1, q2, q3, q4;
    logic [3:0] q_mask;
    logic       frame_done;
    logic [1:0] ptr;

    int n_checks = 0;
    int n_errors = 0;
    int n_pulses = 0;

    // Model state
    logic [3:0]  m_sh [4];
    logic [3:0]  m_q  [4];
    logic [3:0]  m_wmask;
    logic [3:0]  m_qmask;
    logic [1:0]  m_ptr;
    logic        m_commit;
    logic [19:0] sb [$];

    data_dist1_4 #(.WIDTH(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .d          (d),
        .in_sel     (in_sel),
        .auto_mode  (auto_mode),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .flush      (flush),
        .q1         (q1),
        .q2         (q2),
        .q3         (q3),
        .q4         (q4),
        .q_mask     (q_mask),
        .frame_done (frame_done),
        .ptr        (ptr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_sh[i] = 4'h0;
            m_q[i]  = 4'h0;
        end
        m_wmask  = 4'h0;
        m_qmask  = 4'h0;
        m_ptr    = 2'd0;
        m_commit = 1'b0;
        sb.delete();
    endtask

    // Called at a falling edge; drives one cycle and checks after the next rising edge.
    task automatic step(input logic v, input logic [3:0] dd, input logic [1:0] sel,
                        input logic am, input logic fl, output logic acc);
        logic        exp_pulse;
        logic [1:0]  ch;
        logic [19:0] exp_f;
        in_valid  = v;
        d         = dd;
        in_sel    = sel;
        auto_mode = am;
        flush     = fl;
        #1;
        chk("in_ready", in_ready, !m_commit);
        acc       = 1'b0;
        exp_pulse = 1'b0;
        if (m_commit) begin
            for (int i = 0; i < 4; i++)
                if (m_wmask[i]) m_q[i] = m_sh[i];
            m_qmask = m_wmask;
            sb.push_back({m_q[3], m_q[2], m_q[1], m_q[0], m_wmask});
            m_wmask   = 4'h0;
            m_ptr     = 2'd0;
            m_commit  = 1'b0;
            exp_pulse = 1'b1;
        end else begin
            acc = v;
            if (v) begin
                ch       = am ? m_ptr : sel;
                m_sh[ch] = dd;
                m_wmask  = m_wmask | (4'b0001 << ch);
                if (am) m_ptr = m_ptr + 2'd1;
            end
            if ((m_wmask == 4'hF) || (fl && (m_wmask != 4'h0))) m_commit = 1'b1;
        end
        @(posedge clk);
        @(negedge clk);
        chk("frame_done", frame_done, exp_pulse);
        chk("ptr", ptr, m_ptr);
        if (frame_done) begin
            n_pulses++;
            if (sb.size() == 0) begin
                chk("sb_nonempty", sb.size(), 1);
            end else begin
                exp_f = sb.pop_front();
                chk("frame", {q4, q3, q2, q1, q_mask}, exp_f);
            end
        end else begin
            chk("q_hold", {q4, q3, q2, q1, q_mask}, {m_q[3], m_q[2], m_q[1], m_q[0], m_qmask});
        end
    endtask

    task automatic send(input logic [3:0] dd, input logic [1:0] sel, input logic am, input logic fl);
        logic acc;
        acc = 1'b0;
        for (int k = 0; k < 10 && !acc; k++) step(1'b1, dd, sel, am, fl, acc);
        chk("send_accept", acc, 1);
    endtask

    task automatic idle(input int n);
        logic acc;
        for (int k = 0; k < n; k++) step(1'b0, 4'h0, 2'd0, 1'b0, 1'b0, acc);
    endtask

    initial begin
        logic [3:0] word;
        logic       acc;
        int         p0;
        rst_n = 1'b0; d = 4'h0; in_sel = 2'd0; auto_mode = 1'b0; in_valid = 1'b0; flush = 1'b0;
        model_reset();
        #1;
        chk("reset_outs", {q4, q3, q2, q1, q_mask, frame_done, ptr}, 0);
        chk("reset_ready", in_ready, 0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Auto mode, four back-to-back beats
        for (int i = 1; i <= 4; i++) send(4'(i), 2'd0, 1'b1, 1'b0);
        idle(2);
        chk("t1_q", {q4, q3, q2, q1, q_mask}, 20'h4321F);

        // Partial frame plus flush: q3, q4 retained
        send(4'hE, 2'd0, 1'b1, 1'b0);
        send(4'hF, 2'd0, 1'b1, 1'b0);
        step(1'b0, 4'h0, 2'd0, 1'b1, 1'b1, acc);
        idle(2);
        chk("t3_q", {q4, q3, q2, q1, q_mask}, 20'h43FE3);

        // Addressed mode with an overwrite
        send(4'hA, 2'd2, 1'b0, 1'b0);
        send(4'h5, 2'd0, 1'b0, 1'b0);
        send(4'hC, 2'd2, 1'b0, 1'b0);
        send(4'h7, 2'd3, 1'b0, 1'b0);
        chk("t2_no_early", n_pulses, 2);
        send(4'h9, 2'd1, 1'b0, 1'b0);
        idle(2);
        chk("t2_q", {q4, q3, q2, q1, q_mask}, 20'h7C95F);

        // Empty flush is ignored, then flush together with a beat
        p0 = n_pulses;
        step(1'b0, 4'h0, 2'd0, 1'b0, 1'b1, acc);
        idle(2);
        chk("t4_empty_flush", n_pulses, p0);
        send(4'h6, 2'd3, 1'b0, 1'b1);
        idle(2);
        chk("t4_q", {q4, q3, q2, q1, q_mask}, 20'h6C958);

        // Continuous stream, auto mode; the source holds words across COMMIT
        p0   = n_pulses;
        word = 4'h0;
        for (int k = 0; k < 20 && word < 4'd12; k++) begin
            step(1'b1, word, 2'd0, 1'b1, 1'b0, acc);
            if (acc) word = word + 4'd1;
        end
        chk("t5_words", word, 12);
        idle(2);
        chk("t5_commits", n_pulses - p0, 3);
        chk("t5_q", {q4, q3, q2, q1, q_mask}, 20'hBA98F);

        // Asynchronous reset mid-frame
        for (int i = 1; i <= 3; i++) send(4'(i), 2'd0, 1'b1, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_async_outs", {q4, q3, q2, q1, q_mask, frame_done, ptr}, 0);
        chk("rst_async_ready", in_ready, 0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        send(4'h8, 2'd0, 1'b1, 1'b0);
        idle(3);
        chk("t6_ptr", ptr, 1);
        chk("t6_q", {q4, q3, q2, q1, q_mask}, 0);

        chk("sb_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
